pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/hazard_tag_stage.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared tag type, forward-select encoding and defaults for the
//            pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int c_reg_aw_def      = 4;
  localparam int c_flush_depth_def = 2;
  localparam int c_cnt_w_def       = 16;
  localparam int c_zero_reg_def    = 1;
  // Widest register address a tag can carry; narrower addresses are zero-extended.
  localparam int c_rd_max_w        = 8;

  typedef struct packed {
    logic                  valid;
    logic [c_rd_max_w-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } hazard_tag_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  function automatic logic tag_match(
    input hazard_tag_t           tag,
    input logic [c_rd_max_w-1:0] src,
    input logic                  used,
    input logic                  zero_reg
  );
    return tag.valid && tag.regwrite && used && (tag.rd == src) &&
           (!zero_reg || (src != '0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_tag_stage.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tag_stage
// Brief    : One resettable shadow-pipeline tag register.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_tag_stage
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  hazard_tag_t i_tag,
  output hazard_tag_t o_tag
);

  hazard_tag_t r_tag;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_tag <= '0;
    end else begin
      r_tag <= i_tag;
    end
  end

  assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall / flush / forward-select control for a 5-stage pipeline.
//            Define HAZ_FWD_EN for forwarding; otherwise RAW hazards stall.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = c_reg_aw_def,
  parameter int FLUSH_DEPTH = c_flush_depth_def,
  parameter int CNT_W       = c_cnt_w_def,
  parameter int ZERO_REG    = c_zero_reg_def
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              pc_write,
  output logic              de_bubble,
  output logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic       c_zero_reg     = (ZERO_REG != 0);
  localparam logic [1:0] c_flush_reload = 2'(FLUSH_DEPTH - 1);

  hazard_tag_t           w_tag_issue;
  hazard_tag_t           w_tag_ex;
  hazard_tag_t           w_tag_mem;
  hazard_tag_t           w_tag_wb;
  logic [c_rd_max_w-1:0] w_rs1;
  logic [c_rd_max_w-1:0] w_rs2;
  logic                  w_ex_a;
  logic                  w_ex_b;
  logic                  w_mem_a;
  logic                  w_mem_b;
  logic                  w_flush;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_issue;
  logic                  w_unused_tag_bits;
  logic [1:0]            r_flush_cnt;
  logic [CNT_W-1:0]      r_stall_cycles;

  assign w_rs1   = c_rd_max_w'(id_rs1);
  assign w_rs2   = c_rd_max_w'(id_rs2);
  assign w_ex_a  = tag_match(w_tag_ex,  w_rs1, id_use_rs1, c_zero_reg);
  assign w_ex_b  = tag_match(w_tag_ex,  w_rs2, id_use_rs2, c_zero_reg);
  assign w_mem_a = tag_match(w_tag_mem, w_rs1, id_use_rs1, c_zero_reg);
  assign w_mem_b = tag_match(w_tag_mem, w_rs2, id_use_rs2, c_zero_reg);

  // Gating with rst keeps every output idle while reset is held.
  assign w_flush = rst && (br_taken || (r_flush_cnt != 2'd0));

`ifdef HAZ_FWD_EN
  assign w_hazard = w_tag_ex.is_load && (w_ex_a || w_ex_b);
`else
  assign w_hazard = w_ex_a || w_ex_b || w_mem_a || w_mem_b;
`endif

  assign w_stall = w_hazard && !w_flush;
  assign w_issue = id_valid && !w_stall && !w_flush;

  always_comb begin
    w_tag_issue = '0;
    if (w_issue) begin
      w_tag_issue.valid    = 1'b1;
      w_tag_issue.rd       = c_rd_max_w'(id_rd);
      w_tag_issue.regwrite = id_regwrite;
      w_tag_issue.is_load  = id_is_load;
    end
  end

  hazard_tag_stage u_tag_ex  (.clock(clock), .rst(rst), .i_tag(w_tag_issue), .o_tag(w_tag_ex));
  hazard_tag_stage u_tag_mem (.clock(clock), .rst(rst), .i_tag(w_tag_ex),    .o_tag(w_tag_mem));
  hazard_tag_stage u_tag_wb  (.clock(clock), .rst(rst), .i_tag(w_tag_mem),   .o_tag(w_tag_wb));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_flush_cnt    <= 2'd0;
      r_stall_cycles <= '0;
    end else begin
      if (br_taken) begin
        r_flush_cnt <= c_flush_reload;
      end else if (r_flush_cnt != 2'd0) begin
        r_flush_cnt <= r_flush_cnt - 2'd1;
      end
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

`ifdef HAZ_FWD_EN
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;
  fwd_sel_e r_fwd_a;
  fwd_sel_e r_fwd_b;

  // The younger EX producer takes priority over MEM.
  always_comb begin
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_ex_a) begin
      w_fwd_a = FWD_EXMEM;
    end else if (w_mem_a) begin
      w_fwd_a = FWD_MEMWB;
    end
    if (w_ex_b) begin
      w_fwd_b = FWD_EXMEM;
    end else if (w_mem_b) begin
      w_fwd_b = FWD_MEMWB;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else begin
      r_fwd_a <= w_issue ? w_fwd_a : FWD_RF;
      r_fwd_b <= w_issue ? w_fwd_b : FWD_RF;
    end
  end

  assign fwd_a_sel         = r_fwd_a;
  assign fwd_b_sel         = r_fwd_b;
  assign w_unused_tag_bits = ^{w_tag_wb, w_tag_mem.is_load};
`else
  assign fwd_a_sel         = FWD_RF;
  assign fwd_b_sel         = FWD_RF;
  // Write-before-read register file: the WB tag never needs checking.
  assign w_unused_tag_bits = ^{w_tag_wb, w_tag_ex.is_load, w_tag_mem.is_load};
`endif

  assign pc_write     = !w_stall;
  assign de_bubble    = w_stall || w_flush;
  assign flush        = w_flush;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench for pipe_hazard_ctrl against an issue-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_AW      = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 4;
  localparam int ZERO_REG    = 1;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              br_taken;
  logic              pc_write;
  logic              de_bubble;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cycles;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W), .ZERO_REG(ZERO_REG)
  ) dut (
    .clock(clock), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .br_taken(br_taken), .pc_write(pc_write), .de_bubble(de_bubble), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // One issued instruction (or an empty slot) in the history of the last three cycles.
  typedef struct { bit v; int rd; bit rw; bit ld; } slot_t;
  typedef struct { logic pc; logic bub; logic fl; logic [1:0] fa; logic [1:0] fb; int cnt; } exp_t;

  exp_t  sb[$];
  slot_t hist[3];
  int    flush_rem;
  int    m_cnt;
  int    m_sel_a;
  int    m_sel_b;
  bit    want_rst;
  exp_t  last_e;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit dep(input slot_t p, input int s, input bit used);
    return p.v && p.rw && used && (p.rd == s) && !(ZERO_REG != 0 && s == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    flush_rem = 0;
    m_cnt     = 0;
    m_sel_a   = 0;
    m_sel_b   = 0;
  endtask

  // Applies one decode cycle, predicts the outputs for it and advances the model.
  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit br);
    exp_t  e;
    slot_t s;
    bit    fl, d0a, d0b, d1a, d1b, hz, stall, issue;
    int    na, nb;
    @(posedge clock);
    #1;
    rst         = want_rst;
    id_valid    = v;
    id_rs1      = REG_AW'(rs1);
    id_rs2      = REG_AW'(rs2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = REG_AW'(rd);
    id_regwrite = rw;
    id_is_load  = ld;
    br_taken    = br;
    if (!want_rst) begin
      e = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0};
      model_reset();
    end else begin
      fl  = br || (flush_rem > 0);
      d0a = dep(hist[0], rs1, u1);
      d0b = dep(hist[0], rs2, u2);
      d1a = dep(hist[1], rs1, u1);
      d1b = dep(hist[1], rs2, u2);
`ifdef HAZ_FWD_EN
      hz = hist[0].ld && (d0a || d0b);
`else
      hz = d0a || d0b || d1a || d1b;
`endif
      stall = hz && !fl;
      issue = v && !stall && !fl;
      e.pc  = !stall;
      e.bub = stall || fl;
      e.fl  = fl;
      e.fa  = 2'(m_sel_a);
      e.fb  = 2'(m_sel_b);
      e.cnt = m_cnt;
`ifdef HAZ_FWD_EN
      na = !issue ? 0 : d0a ? 1 : d1a ? 2 : 0;
      nb = !issue ? 0 : d0b ? 1 : d1b ? 2 : 0;
`else
      na = 0;
      nb = 0;
`endif
      if (stall && m_cnt < CNT_MAX) m_cnt++;
      flush_rem = br ? FLUSH_DEPTH - 1 : (flush_rem > 0 ? flush_rem - 1 : 0);
      s       = '{issue, rd, rw, ld};
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = issue ? s : '{0, 0, 0, 0};
      m_sel_a = na;
      m_sel_b = nb;
    end
    sb.push_back(e);
    last_e = e;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic brk();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Drops rst between clock edges and expects the outputs to go idle at once.
  task automatic async_reset_check();
    @(negedge clock);
    #1;
    rst      = 1'b0;
    want_rst = 1'b0;
    #1;
    check("async_rst_pc_write", pc_write, 1);
    check("async_rst_de_bubble", de_bubble, 0);
    check("async_rst_flush", flush, 0);
    check("async_rst_fwd_a_sel", fwd_a_sel, 0);
    check("async_rst_fwd_b_sel", fwd_b_sel, 0);
    check("async_rst_stall_cycles", stall_cycles, 0);
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_write", pc_write, e.pc);
        check("de_bubble", de_bubble, e.bub);
        check("flush", flush, e.fl);
        check("fwd_a_sel", fwd_a_sel, e.fa);
        check("fwd_b_sel", fwd_b_sel, e.fb);
        check("stall_cycles", stall_cycles, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int r1, r2, rdv;
    bit v, u1, u2, rw, ld, br;
    rst = 1'b0; id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_regwrite = 0; id_is_load = 0; br_taken = 0;
    want_rst = 1'b0;
    model_reset();
    r1 = 0; r2 = 0; rdv = 0; v = 0; u1 = 0; u2 = 0; rw = 0; ld = 0; br = 0;

    idle();
    brk();
    #3;
    check("reset_pc_write", pc_write, 1);
    check("reset_flush", flush, 0);
    check("reset_stall_cycles", stall_cycles, 0);
    want_rst = 1'b1;

`ifdef HAZ_FWD_EN
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
    drive(1, 3, 1, 0, 0, 6, 1, 0, 0);
    #3;
    check("load_use_pc_write", pc_write, 0);
    check("load_use_de_bubble", de_bubble, 1);
    drive(1, 3, 1, 0, 0, 6, 1, 0, 0);
    #3;
    check("load_use_issue_pc_write", pc_write, 1);
    check("load_use_stall_cycles", stall_cycles, 1);
    idle();
    #3;
    check("load_use_fwd_a_sel", fwd_a_sel, 2);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    #3;
    check("exmem_pc_write", pc_write, 1);
    idle();
    #3;
    check("exmem_fwd_b_sel", fwd_b_sel, 1);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    idle();
    #3;
    check("younger_wins_fwd_a_sel", fwd_a_sel, 1);
`else
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0);
    drive(1, 2, 1, 0, 0, 7, 1, 0, 0);
    #3;
    check("nofwd_stall1_pc_write", pc_write, 0);
    check("nofwd_stall1_de_bubble", de_bubble, 1);
    drive(1, 2, 1, 0, 0, 7, 1, 0, 0);
    #3;
    check("nofwd_stall2_pc_write", pc_write, 0);
    drive(1, 2, 1, 0, 0, 7, 1, 0, 0);
    #3;
    check("nofwd_issue_pc_write", pc_write, 1);
    check("nofwd_stall_cycles", stall_cycles, 2);
    idle();
    #3;
    check("nofwd_fwd_a_sel", fwd_a_sel, 0);
`endif

    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 1, 0, 0, 8, 1, 0, 0);
    #3;
    check("zero_reg_pc_write", pc_write, 1);

    brk();
    #3;
    check("flush1_c1", flush, 1);
    check("flush1_c1_pc_write", pc_write, 1);
    idle();
    #3;
    check("flush1_c2", flush, 1);
    idle();
    #3;
    check("flush1_c3", flush, 0);
    brk();
    #3;
    check("flush2_c1", flush, 1);
    brk();
    #3;
    check("flush2_c2", flush, 1);
    idle();
    #3;
    check("flush2_c3", flush, 1);
    idle();
    #3;
    check("flush2_c4", flush, 0);

    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    drive(1, 7, 1, 0, 0, 9, 1, 0, 1);
    #3;
    check("coincident_flush", flush, 1);
    check("coincident_pc_write", pc_write, 1);
    check("coincident_de_bubble", de_bubble, 1);
    idle();
    idle();
    idle();

    for (int i = 0; i < 3000; i++) begin
      if (last_e.pc) begin
        v   = ($urandom_range(0, 4) != 0);
        r1  = $urandom_range(0, 5);
        r2  = $urandom_range(0, 5);
        rdv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
        u1  = ($urandom_range(0, 3) != 0);
        u2  = ($urandom_range(0, 3) != 0);
        rw  = ($urandom_range(0, 3) != 0);
        ld  = ($urandom_range(0, 2) == 0);
      end
      br = ($urandom_range(0, 11) == 0);
      drive(v, r1, u1, r2, u2, rdv, rw, ld, br);
      if (i > 1500 && last_e.bub && $urandom_range(0, 24) == 0) begin
        async_reset_check();
        drive(v, r1, u1, r2, u2, rdv, rw, ld, br);
        want_rst = 1'b1;
      end
    end

    idle();
    @(negedge clock);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
